mux_nto1_rr: RTL
================

Name: mux_nto1_rr

Overview:
- Registered N-input, W-bit-wide multiplexer with per-input valid/ready handshake and a one-entry output register.
- Two selection modes:
  - fixed: the external `sel` picks the input.
  - round-robin: fair arbitration among the valid inputs.
- Successor to the combinational 2:1 32-bit datapath mux.
- Sits between multiple producers (e.g. register-file read ports or ALU result sources) and a single downstream consumer that can apply backpressure.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of inputs (2..16; need not be a power of two).
- SEL_W, $clog2(NUM_IN), width of `sel` and `out_src`. Derived; not overridden.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  input index used in fixed mode.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input i occupies [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-input data valid.
- in_ready  output  NUM_IN  per-input accept strobe, one-hot or zero.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_src  output  SEL_W  index of the input that supplied out_data.
- xfer_count  output  CNT_W  number of words accepted from the inputs, wrapping.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_src=0, xfer_count=0, rr_ptr=0.
  - in_ready is combinational; it is all-zero while reset is high.
- Reset asserted mid-transfer discards the held word. No in_ready is asserted in the reset cycle.
- Output register state:
  - load_en = !out_valid | out_ready.
  - The register loads when load_en is high and a grant exists.
- Grant, fixed mode (mode=0):
  - Grant to input `sel` iff in_valid[sel]=1.
  - No grant if `sel` >= NUM_IN.
  - Other inputs are never granted, even when valid.
- Grant, round-robin mode (mode=1):
  - Grant to the first i with in_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_IN.
- Ready: in_ready[i] = load_en & grant_valid & (grant==i). At most one bit is set.
- On load (edge):
  - out_data <= the granted input's data, out_src <= grant, out_valid <= 1.
  - xfer_count <= xfer_count+1, wrapping to 0 from all-ones.
- rr_ptr:
  - Updates only on a load in round-robin mode: rr_ptr <= (grant==NUM_IN-1) ? 0 : grant+1.
  - Unchanged in fixed mode.
- Drain without load: out_ready=1 and no grant gives out_valid <= 0. out_data and out_src keep their last values.
- Simultaneous drain and load: out_ready=1 with a grant replaces the word in the same cycle, giving full throughput of 1 word/cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_src and out_valid are held stable.
  - all in_ready are 0.
  - rr_ptr and xfer_count are frozen.
- Latency: a word accepted at edge k appears on out_data after edge k (1 cycle).
- mode or sel changes:
  - take effect on the next grant evaluation.
  - never alter a held output word.
  - do not reset rr_ptr.
- No in_valid bits set: no grant and no state change, except a drain if out_ready=1.
- Width rules:
  - Data passes through unmodified; there is no arithmetic on data.
  - out_src is zero-extended when NUM_IN < 2**SEL_W.

Decomposition:
- Shared package `mux_pkg` holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - The localparam helper for SEL_W.
- One natural sub-module, `rr_arbiter`:
  - Parameters: NUM_IN.
  - Inputs: req[NUM_IN-1:0] and ptr.
  - Outputs: gnt_valid and gnt_idx.
  - Purely combinational, using a double-width mask-and-priority search.
- The top level contains:
  - the fixed/round-robin grant select.
  - the output register, rr_ptr and counter.
  - the in_data slicing.

Test Plan:
1. Reset, then mode=0, sel=1, WIDTH=32, in_valid=4'b0011, input0=32'hAAAAAAAA, input1=32'h55555555, out_ready=1.
   - Required: in_ready=4'b0010.
   - Next cycle: out_data=32'h55555555, out_src=1, out_valid=1, xfer_count=1.
2. mode=1, all 4 inputs valid continuously, input i=i+1, out_ready=1.
   - Required: out_src sequence 0,1,2,3,0,…
   - out_data sequence 1,2,3,4,1,…
   - one word per cycle.
3. mode=1, out_valid=1 with out_ready=0 held for 5 cycles.
   - Required: out_data and out_src stable, in_ready=0, xfer_count unchanged.
   - When out_ready rises: drain and reload in the same cycle.
4. mode=1, rr_ptr=3, in_valid=4'b0101.
   - Required: grant=0 (wrap-around), then rr_ptr=1, next grant=2.
5. NUM_IN=3 build, mode=0, sel=3.
   - Required: no in_ready, out_valid falls to 0 after the drain.
6. Assert reset while out_valid=1 and inputs are valid.
   - Required: the next cycle shows out_valid=0, out_data=0 and xfer_count=0.
   - Force xfer_count=16'hFFFF, then one transfer: required xfer_count=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered mux: mode encodings and select-width helper.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo NUM_IN.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [2*NUM_IN-1:0] req2;
    logic [2*NUM_IN-1:0] masked;

    always_comb begin
        req2      = {req, req};
        masked    = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Upper copy of req supplies the wrapped-around candidates below ptr.
        for (int j = 0; j < 2 * NUM_IN; j++) begin
            masked[j] = req2[j] && (j >= int'(ptr));
        end
        for (int j = 2 * NUM_IN - 1; j >= 0; j--) begin
            if (masked[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'((j >= NUM_IN) ? (j - NUM_IN) : j);
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// Registered N:1 mux with valid/ready handshake, fixed or round-robin selection and a transfer counter.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic [CNT_W-1:0]        xfer_count
);

    logic [WIDTH-1:0] in_word [NUM_IN];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             fixed_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             load;

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_word[i] = in_data[i*WIDTH +: WIDTH];
        end

        // An out-of-range sel simply matches no input, so it never grants.
        fixed_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if ((int'(sel) == i) && in_valid[i]) fixed_valid = 1'b1;
        end

        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant       = rr_idx;
        end else begin
            grant_valid = fixed_valid;
            grant       = sel;
        end

        load_en = !out_valid_q || out_ready;
        load    = load_en && grant_valid && !reset;

        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(grant) == i) begin
                in_ready[i] = load;
                grant_data  = in_word[i];
            end
        end

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        xfer_count_d = xfer_count_q;
        rr_ptr_d     = rr_ptr_q;

        if (load) begin
            out_valid_d  = 1'b1;
            out_data_d   = grant_data;
            out_src_d    = grant;
            xfer_count_d = xfer_count_q + CNT_W'(1);
            if (mode == MODE_RR) begin
                rr_ptr_d = (int'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            xfer_count_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            xfer_count_q <= xfer_count_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign xfer_count = xfer_count_q;

endmodule
